// File: rtl/uart_frame_scheduler.sv
// Two-source round-robin arbiter that frames the granted word as one header byte
// followed by its data bytes (LSB first) for a byte-wide UART transmitter.
module uart_frame_scheduler #(
  parameter int unsigned WORD_BITS   = 64,
  parameter logic [7:0]  HEADER_BASE = 8'hA0
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 req0_valid_in,
  input  logic [WORD_BITS-1:0] req0_data_in,
  output logic                 req0_ready_out,
  input  logic                 req1_valid_in,
  input  logic [WORD_BITS-1:0] req1_data_in,
  output logic                 req1_ready_out,
  output logic [7:0]           uart_data_out,
  output logic                 uart_trigger_out,
  input  logic                 uart_busy_in,
  output logic                 busy_out,
  output logic                 last_grant_out,
  output logic [15:0]          frame_count_out
);

  localparam int unsigned NBYTES  = WORD_BITS / 8;
  localparam int unsigned SR_BITS = (NBYTES + 1) * 8;
  localparam int unsigned CNT_W   = $clog2(NBYTES + 1);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FIRE       = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [SR_BITS-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_grant_q, last_grant_d;
  logic [15:0]        frame_count_q, frame_count_d;

  logic               sel;
  logic [WORD_BITS-1:0] grant_word;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= IDLE;
      sr_q          <= '0;
      cnt_q         <= '0;
      last_grant_q  <= 1'b1;
      frame_count_q <= 16'h0000;
    end else begin
      state_q       <= state_d;
      sr_q          <= sr_d;
      cnt_q         <= cnt_d;
      last_grant_q  <= last_grant_d;
      frame_count_q <= frame_count_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    sr_d             = sr_q;
    cnt_d            = cnt_q;
    last_grant_d     = last_grant_q;
    frame_count_d    = frame_count_q;
    req0_ready_out   = 1'b0;
    req1_ready_out   = 1'b0;
    uart_trigger_out = 1'b0;

    // On a tie the source that did not win last time goes next.
    if (req0_valid_in && req1_valid_in) begin
      sel = ~last_grant_q;
    end else if (req1_valid_in) begin
      sel = 1'b1;
    end else begin
      sel = 1'b0;
    end
    grant_word = sel ? req1_data_in : req0_data_in;

    case (state_q)
      IDLE: begin
        req0_ready_out = req0_valid_in && !sel;
        req1_ready_out = req1_valid_in && sel;
        if (req0_ready_out || req1_ready_out) begin
          sr_d         = {grant_word, HEADER_BASE + 8'(sel)};
          last_grant_d = sel;
          cnt_d        = '0;
          state_d      = FIRE;
        end else begin
          state_d      = IDLE;
        end
      end
      FIRE: begin
        uart_trigger_out = !uart_busy_in;
        if (!uart_busy_in) begin
          state_d = WAIT_START;
        end else begin
          state_d = FIRE;
        end
      end
      WAIT_START: begin
        if (uart_busy_in) begin
          state_d = WAIT_DONE;
        end else begin
          state_d = WAIT_START;
        end
      end
      WAIT_DONE: begin
        if (!uart_busy_in) begin
          if (cnt_q == LAST_BYTE) begin
            frame_count_d = frame_count_q + 16'd1;
            state_d       = IDLE;
          end else begin
            sr_d    = sr_q >> 8;
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = FIRE;
          end
        end else begin
          state_d = WAIT_DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign uart_data_out   = sr_q[7:0];
  assign busy_out        = (state_q != IDLE);
  assign last_grant_out  = last_grant_q;
  assign frame_count_out = frame_count_q;

endmodule

// File: doc/uart_frame_scheduler.md
# uart_frame_scheduler

Arbitrates between two word producers and serializes the granted word into a framed byte stream for the shared `uart_transmit` instance. The block sits between the election datapath, where ballot and ciphertext sources raise requests, and the FPGA-to-PC UART transmitter. It drives that transmitter's `data_byte_in` and `trigger_in` ports and watches its `busy_out`. Each frame is one header byte identifying the source, followed by the word bytes in LSB-first order.

## Interface
- `WORD_BITS`, default 64: width of each requester's word. Must be a multiple of 8 and at least 8. `NBYTES = WORD_BITS/8`.
- `HEADER_BASE`, default 8'hA0: header byte is `HEADER_BASE + source_index`. Source 0 sends 8'hA0; source 1 sends 8'hA1.

Ports:
- `clk_in` input 1: system clock, 100 MHz. One clock domain.
- `rst_in` input 1: reset, synchronous, active-high.
- `req0_valid_in` input 1: source 0 has a word to send.
- `req0_data_in` input WORD_BITS: source 0 word.
- `req0_ready_out` output 1: source 0 word accepted when this and `req0_valid_in` are both high at a clock edge.
- `req1_valid_in`, `req1_data_in`, `req1_ready_out`: same as above, for source 1.
- `uart_data_out` output 8: byte to the transmitter's `data_byte_in`.
- `uart_trigger_out` output 1: one-cycle start pulse to the transmitter's `trigger_in`.
- `uart_busy_in` input 1: the transmitter's `busy_out`.
- `busy_out` output 1: high whenever a frame is in progress.
- `last_grant_out` output 1: index of the most recently granted source.
- `frame_count_out` output 16: count of completed frames; wraps from 16'hFFFF to 0.

## Operation
- States: IDLE, FIRE, WAIT_START, WAIT_DONE.
- **IDLE**
  - `sel` is computed combinationally:
    - If only one source is valid, `sel` is that source.
    - If both are valid, `sel = ~last_grant`.
  - `reqN_ready_out = (state==IDLE) && reqN_valid_in && (sel==N)`. At most one ready is high in any cycle.
  - On acceptance:
    - Latch `{word, header}` into a shift register of `(NBYTES+1)*8` bits, header in the lowest byte.
    - Set `last_grant <= sel`, `byte_cnt <= 0`, and go to FIRE.
- **FIRE**
  - `uart_data_out` = shift register bits [7:0].
  - `uart_trigger_out = !uart_busy_in`.
  - If `uart_busy_in` is low, go to WAIT_START. Otherwise stay in FIRE with trigger held low.
- **WAIT_START**
  - Stay until `uart_busy_in` is high, then go to WAIT_DONE.
- **WAIT_DONE**
  - Stay until `uart_busy_in` is low.
  - If `byte_cnt == NBYTES`:
    - Increment `frame_count`.
    - Go to IDLE.
  - Otherwise:
    - Shift right by 8.
    - Increment `byte_cnt`.
    - Go to FIRE.
- `uart_data_out` holds stable from FIRE through the end of WAIT_DONE for each byte.
- `busy_out = (state != IDLE)`.
- Width rule: `byte_cnt` is `$clog2(NBYTES+1)` bits and must never overflow.
- Valid inputs arriving while not in IDLE are ignored; the producer holds valid until it sees ready. The block never buffers a second word.

## Timing
- Reset values:
  - state = IDLE.
  - All ready outputs = 0, `uart_trigger_out` = 0, `uart_data_out` = 8'h00.
  - `busy_out` = 0, `last_grant_out` = 1, so source 0 wins the first tie.
  - `frame_count_out` = 0.
- Reset mid-frame: return to IDLE on the next edge and discard the remaining bytes. The transmitter is reset by the same `rst_in`.
- Latency:
  - Acceptance at edge T puts the state in FIRE during cycle T+1.
  - The header trigger is high in cycle T+1 if the transmitter is idle.
- Inter-byte gap: the falling `uart_busy_in` is seen in WAIT_DONE at cycle C. The next trigger is in cycle C+1, so there is exactly one idle cycle between bytes.
- End of frame to next acceptance: the earliest next ready is in cycle C+1.
- The transmitter raises `busy_out` one cycle after the trigger. WAIT_START tolerates any delay of at least 1 cycle.

## Test plan
- **Single source.** Setup: WORD_BITS=16; transmitter model raises busy 1 cycle after trigger for 10 cycles.
  - Stimulus: `req0` with 16'hBEEF.
  - Required: bytes A0, EF, BE; exactly 3 triggers, each 1 cycle wide; one-cycle gap between each busy fall and the next trigger; `frame_count_out` reads 1; `busy_out` low afterwards.
- **Simultaneous requests.** Stimulus: both sources valid out of reset, data 16'h1111 and 16'h2222, held until ready.
  - Required: frame from source 0 (A0 11 11), then source 1 (A1 22 22); `last_grant_out` reads 0, then 1.
- **Round-robin fairness.** Stimulus: both sources valid continuously for 4 frames.
  - Required: headers A0, A1, A0, A1.
- **Busy at start.** Stimulus: `uart_busy_in` forced high when entering FIRE, released 5 cycles later.
  - Required: trigger stays low for those 5 cycles, then exactly one trigger pulse; no byte lost.
- **Reset mid-frame.** Stimulus: assert `rst_in` during WAIT_DONE of byte 1.
  - Required: next cycle shows state IDLE, trigger 0, `busy_out` 0, `frame_count_out` 0.
  - Required: a following `req1` with 16'h0102 sends A1 02 01.
- **Counter wrap.** Stimulus: preload by running frames until `frame_count_out` = 16'hFFFF, then complete one more frame.
  - Required: `frame_count_out` reads 16'h0000.
